// File: rtl/io_port_pkg.sv
// Shared address map, CTRL bit positions and bus request/strobe types for io_port_gen.
package io_port_pkg;

  localparam int IO_ADDR_W = 8;
  localparam int IO_DATA_W = 32;

  localparam logic [IO_ADDR_W-1:0] IO_OUT_BASE    = 8'h00;
  localparam logic [IO_ADDR_W-1:0] IO_IN_BASE     = 8'h20;
  localparam logic [IO_ADDR_W-1:0] IO_DIR_BASE    = 8'h40;
  localparam logic [IO_ADDR_W-1:0] IO_MTIME_LO    = 8'h60;
  localparam logic [IO_ADDR_W-1:0] IO_MTIME_HI    = 8'h64;
  localparam logic [IO_ADDR_W-1:0] IO_MTIMECMP_LO = 8'h68;
  localparam logic [IO_ADDR_W-1:0] IO_MTIMECMP_HI = 8'h6C;
  localparam logic [IO_ADDR_W-1:0] IO_CTRL        = 8'h70;

  localparam int CTRL_TEN = 0;
  localparam int CTRL_IEN = 1;

  typedef struct packed {
    logic                 en;
    logic                 we;
    logic [IO_ADDR_W-1:0] addr;
    logic [IO_DATA_W-1:0] wdata;
  } io_req_t;

  // One write strobe per timer register.
  typedef struct packed {
    logic lo;
    logic hi;
    logic cmp_lo;
    logic cmp_hi;
    logic ctrl;
  } tmr_sel_t;

endpackage

// File: rtl/io_mtimer.sv
// Machine timer: prescaler, mtime/mtimecmp, atomic-read hi shadow and registered compare interrupt.
module io_mtimer
  import io_port_pkg::*;
#(
  parameter int MTIME_W  = 64,
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  tmr_sel_t    wr_sel,
  input  logic        rd_lo,
  input  logic [31:0] wdata,
  output logic [31:0] mtime_lo,
  output logic [31:0] hi_shadow_rd,
  output logic [31:0] cmp_lo_rd,
  output logic [31:0] cmp_hi_rd,
  output logic [31:0] ctrl_rd,
  output logic        irq
);

  localparam int HI_W = MTIME_W - 32;
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [MTIME_W-1:0] mtime, mtimecmp, mtime_inc;
  logic [HI_W-1:0]    hi_shadow;
  logic [1:0]         ctrl;
  logic [PS_W-1:0]    ps_cnt;
  logic               ten, ien, tick;

  assign ten       = ctrl[CTRL_TEN];
  assign ien       = ctrl[CTRL_IEN];
  assign tick      = ten && (ps_cnt == PS_LAST);
  assign mtime_inc = mtime + MTIME_W'(tick);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             ps_cnt <= '0;
    else if (!ten || tick) ps_cnt <= '0;
    else                   ps_cnt <= ps_cnt + 1'b1;
  end

  // A bus write owns its half; writing LO also blocks the carry into HI.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime <= '0;
    end else begin
      mtime[31:0] <= wr_sel.lo ? wdata : mtime_inc[31:0];
      if (wr_sel.hi)      mtime[MTIME_W-1:32] <= wdata[HI_W-1:0];
      else if (!wr_sel.lo) mtime[MTIME_W-1:32] <= mtime_inc[MTIME_W-1:32];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtimecmp  <= '1;
      hi_shadow <= '0;
      ctrl      <= '0;
      irq       <= 1'b0;
    end else begin
      if (wr_sel.cmp_lo) mtimecmp[31:0]         <= wdata;
      if (wr_sel.cmp_hi) mtimecmp[MTIME_W-1:32] <= wdata[HI_W-1:0];
      if (wr_sel.ctrl)   ctrl                   <= wdata[1:0];
      if (rd_lo)         hi_shadow              <= mtime[MTIME_W-1:32];
      irq <= ien && (mtime >= mtimecmp);
    end
  end

  always_comb begin
    mtime_lo                = mtime[31:0];
    cmp_lo_rd               = mtimecmp[31:0];
    hi_shadow_rd            = '0;
    hi_shadow_rd[HI_W-1:0]  = hi_shadow;
    cmp_hi_rd               = '0;
    cmp_hi_rd[HI_W-1:0]     = mtimecmp[MTIME_W-1:32];
    ctrl_rd                 = '0;
    ctrl_rd[1:0]            = ctrl;
  end

endmodule

// File: rtl/io_port_gen.sv
// Parametrised GPIO + machine-timer port on the core io bus: decode, GPIO registers,
// input synchroniser and registered read mux.
module io_port_gen
  import io_port_pkg::*;
#(
  parameter int N_GPIO   = 1,
  parameter int GPIO_W   = 8,
  parameter int MTIME_W  = 64,
  parameter int PRESCALE = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IO_ADDR_W-1:0]     io_addr,
  input  logic                     io_en,
  input  logic                     io_we,
  input  logic [IO_DATA_W-1:0]     io_data_write,
  output logic [IO_DATA_W-1:0]     io_data_read,
  output logic                     irq_mtimecmp,
  input  logic [N_GPIO*GPIO_W-1:0] gpio_in,
  output logic [N_GPIO*GPIO_W-1:0] gpio_out,
  output logic [N_GPIO*GPIO_W-1:0] gpio_oe
);

  io_req_t  req;
  tmr_sel_t tmr_wr;
  logic     wr, rd, hit_out, hit_in, hit_dir, unused_addr_bits;
  logic [2:0] ch;
  logic [IO_DATA_W-1:0] rd_mux, t_lo, t_hi, t_cmp_lo, t_cmp_hi, t_ctrl;
  logic [N_GPIO-1:0][GPIO_W-1:0] out_q, dir_q, sync1, sync2;

  assign req = '{en: io_en, we: io_we, addr: {io_addr[7:2], 2'b00}, wdata: io_data_write};
  assign unused_addr_bits = ^io_addr[1:0];

  assign wr      = req.en && req.we;
  assign rd      = req.en && !req.we;
  assign ch      = req.addr[4:2];
  assign hit_out = (req.addr[7:5] == IO_OUT_BASE[7:5]);
  assign hit_in  = (req.addr[7:5] == IO_IN_BASE[7:5]);
  assign hit_dir = (req.addr[7:5] == IO_DIR_BASE[7:5]);

  assign tmr_wr = '{lo:     wr && (req.addr == IO_MTIME_LO),
                    hi:     wr && (req.addr == IO_MTIME_HI),
                    cmp_lo: wr && (req.addr == IO_MTIMECMP_LO),
                    cmp_hi: wr && (req.addr == IO_MTIMECMP_HI),
                    ctrl:   wr && (req.addr == IO_CTRL)};

  // Channels k >= N_GPIO have no flops, so writes there fall away naturally.
  for (genvar k = 0; k < N_GPIO; k++) begin : g_ch
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_q[k] <= '0;
        dir_q[k] <= '0;
      end else if (wr && ch == 3'(k)) begin
        if (hit_out) out_q[k] <= req.wdata[GPIO_W-1:0];
        if (hit_dir) dir_q[k] <= req.wdata[GPIO_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;

  io_mtimer #(.MTIME_W(MTIME_W), .PRESCALE(PRESCALE)) u_mtimer (
    .clk          (clk),
    .reset        (reset),
    .wr_sel       (tmr_wr),
    .rd_lo        (rd && (req.addr == IO_MTIME_LO)),
    .wdata        (req.wdata),
    .mtime_lo     (t_lo),
    .hi_shadow_rd (t_hi),
    .cmp_lo_rd    (t_cmp_lo),
    .cmp_hi_rd    (t_cmp_hi),
    .ctrl_rd      (t_ctrl),
    .irq          (irq_mtimecmp)
  );

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < N_GPIO; k++) begin
      if (ch == 3'(k)) begin
        if (hit_out) rd_mux[GPIO_W-1:0] = out_q[k];
        if (hit_in)  rd_mux[GPIO_W-1:0] = sync2[k];
        if (hit_dir) rd_mux[GPIO_W-1:0] = dir_q[k];
      end
    end
    case (req.addr)
      IO_MTIME_LO:    rd_mux = t_lo;
      IO_MTIME_HI:    rd_mux = t_hi;
      IO_MTIMECMP_LO: rd_mux = t_cmp_lo;
      IO_MTIMECMP_HI: rd_mux = t_cmp_hi;
      IO_CTRL:        rd_mux = t_ctrl;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)   io_data_read <= '0;
    else if (rd) io_data_read <= rd_mux;
  end

endmodule
